// File: rtl/absorb_mem_sequencer.sv
// Single owner of the absorption-matrix memory: zero-fill sweep, calculator
// read-modify-write passthrough, and host readout as 32-bit halves.
module absorb_mem_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_clear_i,
  input  logic                  calc_done_i,
  input  logic [ADDR_WIDTH-1:0] calc_rdaddress_i,
  input  logic [ADDR_WIDTH-1:0] calc_wraddress_i,
  input  logic [WORD_WIDTH-1:0] calc_data_i,
  input  logic                  calc_wren_i,
  output logic [WORD_WIDTH-1:0] calc_q_o,
  output logic                  calc_reset_o,
  input  logic                  host_inc_i,
  output logic [31:0]           host_result_o,
  output logic                  host_valid_o,
  output logic                  readout_done_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress_o,
  output logic [ADDR_WIDTH-1:0] mem_wraddress_o,
  output logic [WORD_WIDTH-1:0] mem_data_o,
  output logic                  mem_wren_o,
  input  logic [WORD_WIDTH-1:0] mem_q_i
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    CALC,
    READ_WAIT,
    READOUT,
    FINISHED
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] AddrLast = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  toggle_q, toggle_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      toggle_q <= toggle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    toggle_d = toggle_q;

    mem_rdaddress_o = '0;
    mem_wraddress_o = '0;
    mem_data_o      = '0;
    mem_wren_o      = 1'b0;
    calc_reset_o    = 1'b1;
    busy_o          = 1'b0;
    host_valid_o    = 1'b0;
    host_result_o   = '0;
    readout_done_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_clear_i) begin
          state_d  = CLEAR;
          wr_cnt_d = '0;
        end
      end

      CLEAR: begin
        busy_o          = 1'b1;
        mem_wraddress_o = wr_cnt_q;
        mem_wren_o      = 1'b1;
        wr_cnt_d        = wr_cnt_q + 1'b1;
        if (wr_cnt_q == AddrLast) begin
          state_d = CALC;
        end
      end

      CALC: begin
        busy_o          = 1'b1;
        calc_reset_o    = 1'b0;
        mem_rdaddress_o = calc_rdaddress_i;
        mem_wraddress_o = calc_wraddress_i;
        mem_data_o      = calc_data_i;
        // A write arriving alongside calc_done is dropped so the readout sees a settled matrix.
        mem_wren_o      = calc_wren_i & ~calc_done_i;
        if (calc_done_i) begin
          state_d  = READ_WAIT;
          rd_cnt_d = '0;
          toggle_d = 1'b0;
        end
      end

      READ_WAIT: begin
        busy_o          = 1'b1;
        calc_reset_o    = 1'b0;
        mem_rdaddress_o = rd_cnt_q;
        state_d         = READOUT;
      end

      READOUT: begin
        busy_o          = 1'b1;
        calc_reset_o    = 1'b0;
        mem_rdaddress_o = rd_cnt_q;
        host_valid_o    = 1'b1;
        host_result_o   = toggle_q ? mem_q_i[31:0] : mem_q_i[63:32];
        if (host_inc_i) begin
          toggle_d = ~toggle_q;
          if (toggle_q) begin
            if (rd_cnt_q == AddrLast) begin
              state_d = FINISHED;
            end else begin
              rd_cnt_d = rd_cnt_q + 1'b1;
              state_d  = READ_WAIT;
            end
          end
        end
      end

      FINISHED: begin
        readout_done_o = 1'b1;
        if (start_clear_i) begin
          state_d  = CLEAR;
          wr_cnt_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign calc_q_o = mem_q_i;

endmodule

// File: tb/tb_absorb_mem_sequencer.sv
// Directed bench for absorb_mem_sequencer with a behavioral 1-cycle-latency
// dual-port memory; ADDR_WIDTH is shrunk to 4 so sweeps stay short.
module tb_absorb_mem_sequencer;

  localparam int AW = 4;
  localparam int WW = 64;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic          startClear;
  logic          calcDone;
  logic [AW-1:0] calcRdAddress;
  logic [AW-1:0] calcWrAddress;
  logic [WW-1:0] calcData;
  logic          calcWren;
  logic [WW-1:0] calcQ;
  logic          calcReset;
  logic          hostInc;
  logic [31:0]   hostResult;
  logic          hostValid;
  logic          readoutDone;
  logic          busy;
  logic [AW-1:0] memRdAddress;
  logic [AW-1:0] memWrAddress;
  logic [WW-1:0] memData;
  logic          memWren;
  logic [WW-1:0] memQ;

  logic [WW-1:0] memArray [DEPTH];
  logic [WW-1:0] expWord  [DEPTH];

  int checkCount = 0;
  int passCount  = 0;

  localparam logic [WW-1:0] WORD0 = 64'hAABBCCDD00112233;
  localparam logic [WW-1:0] WORD1 = 64'h0102030405060708;
  localparam logic [WW-1:0] WORD5 = 64'h1122334455667788;

  absorb_mem_sequencer #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .start_clear_i    (startClear),
    .calc_done_i      (calcDone),
    .calc_rdaddress_i (calcRdAddress),
    .calc_wraddress_i (calcWrAddress),
    .calc_data_i      (calcData),
    .calc_wren_i      (calcWren),
    .calc_q_o         (calcQ),
    .calc_reset_o     (calcReset),
    .host_inc_i       (hostInc),
    .host_result_o    (hostResult),
    .host_valid_o     (hostValid),
    .readout_done_o   (readoutDone),
    .busy_o           (busy),
    .mem_rdaddress_o  (memRdAddress),
    .mem_wraddress_o  (memWrAddress),
    .mem_data_o       (memData),
    .mem_wren_o       (memWren),
    .mem_q_i          (memQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory; a same-address read during write returns the old word.
  always @(posedge clk) begin
    if (memWren) memArray[memWrAddress] <= memData;
    memQ <= memArray[memRdAddress];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [WW-1:0] observed,
                             input logic [WW-1:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sc, input logic cd, input logic hi);
    startClear = sc;
    calcDone   = cd;
    hostInc    = hi;
  endtask

  initial begin
    logic [WW-1:0] w;

    reset = 1'b1;
    calcRdAddress = '0;
    calcWrAddress = '0;
    calcData = '0;
    calcWren = 1'b0;
    applyStimulus(0, 0, 0);
    memQ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      memArray[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
      expWord[i]  = '0;
    end
    expWord[0] = WORD0;
    expWord[1] = WORD1;
    expWord[5] = WORD5;

    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset_wren", 64'(memWren), 0);
    checkOutput("reset_calc_reset", 64'(calcReset), 1);
    checkOutput("reset_busy", 64'(busy), 0);
    checkOutput("reset_host_valid", 64'(hostValid), 0);
    checkOutput("reset_readout_done", 64'(readoutDone), 0);
    checkOutput("reset_host_result", 64'(hostResult), 0);
    checkOutput("reset_wraddr", 64'(memWrAddress), 0);

    // Zero-fill sweep over all 16 words.
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 1, 1);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("clear_wren_%0d", i), 64'(memWren), 1);
      checkOutput($sformatf("clear_addr_%0d", i), 64'(memWrAddress), 64'(i));
      checkOutput($sformatf("clear_data_%0d", i), memData, 0);
      checkOutput($sformatf("clear_calc_reset_%0d", i), 64'(calcReset), 1);
      tick();
    end
    applyStimulus(0, 0, 0);
    checkOutput("calc_busy", 64'(busy), 1);
    checkOutput("calc_calc_reset", 64'(calcReset), 0);
    checkOutput("calc_idle_wren", 64'(memWren), 0);
    checkOutput("clear_zeroed_3", memArray[3], 0);
    checkOutput("clear_zeroed_15", memArray[15], 0);

    // Calculator passthrough.
    calcWren = 1'b1;
    calcWrAddress = 4'd5;
    calcData = WORD5;
    calcRdAddress = 4'd9;
    #1;
    checkOutput("pass_wren", 64'(memWren), 1);
    checkOutput("pass_wraddr", 64'(memWrAddress), 5);
    checkOutput("pass_data", memData, WORD5);
    checkOutput("pass_rdaddr", 64'(memRdAddress), 9);
    tick();
    calcWrAddress = 4'd0;
    calcData = WORD0;
    calcRdAddress = 4'd5;
    tick();
    checkOutput("pass_calc_q", calcQ, WORD5);
    calcWrAddress = 4'd1;
    calcData = WORD1;
    tick();
    calcWrAddress = 4'd2;
    calcData = 64'hFFFF_FFFF_FFFF_FFFF;
    applyStimulus(0, 1, 0);
    #1;
    checkOutput("done_cycle_wren", 64'(memWren), 0);
    tick();
    calcWren = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("word2_untouched", memArray[2], 0);

    // Readout of all words as hi/lo halves.
    for (int wd = 0; wd < DEPTH; wd++) begin
      w = expWord[wd];
      checkOutput($sformatf("rw_valid_%0d", wd), 64'(hostValid), 0);
      checkOutput($sformatf("rw_result_%0d", wd), 64'(hostResult), 0);
      checkOutput($sformatf("rw_rdaddr_%0d", wd), 64'(memRdAddress), 64'(wd));
      checkOutput($sformatf("rw_busy_%0d", wd), 64'(busy), 1);
      tick();
      checkOutput($sformatf("ro_valid_%0d", wd), 64'(hostValid), 1);
      checkOutput($sformatf("ro_hi_%0d", wd), 64'(hostResult), 64'(w[63:32]));
      // Without host_inc the half must hold.
      tick();
      checkOutput($sformatf("ro_hold_%0d", wd), 64'(hostResult), 64'(w[63:32]));
      applyStimulus(0, 0, 1);
      tick();
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("ro_lo_%0d", wd), 64'(hostResult), 64'(w[31:0]));
      applyStimulus(0, 0, 1);
      tick();
      applyStimulus(0, 0, 0);
    end

    checkOutput("fin_readout_done", 64'(readoutDone), 1);
    checkOutput("fin_host_valid", 64'(hostValid), 0);
    checkOutput("fin_calc_reset", 64'(calcReset), 1);
    checkOutput("fin_busy", 64'(busy), 0);
    applyStimulus(0, 1, 1);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("fin_ignore_inc", 64'(readoutDone), 1);
    checkOutput("fin_ignore_valid", 64'(hostValid), 0);

    // Restart, then abandon the sweep with reset at wr_cnt=7.
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("restart_wren", 64'(memWren), 1);
    checkOutput("restart_addr", 64'(memWrAddress), 0);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("midclear_addr", 64'(memWrAddress), 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("midreset_wren", 64'(memWren), 0);
    checkOutput("midreset_busy", 64'(busy), 0);
    checkOutput("midreset_calc_reset", 64'(calcReset), 1);
    checkOutput("midreset_word9_kept", memArray[9], 0);
    applyStimulus(0, 1, 1);
    tick();
    applyStimulus(0, 0, 0);
    tick();
    checkOutput("idle_ignore_busy", 64'(busy), 0);
    checkOutput("idle_ignore_wren", 64'(memWren), 0);
    checkOutput("idle_ignore_valid", 64'(hostValid), 0);
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("resweep_addr0", 64'(memWrAddress), 0);
    tick();
    checkOutput("resweep_addr1", 64'(memWrAddress), 1);
    checkOutput("resweep_wren", 64'(memWren), 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/absorb_mem_sequencer.md
# absorb_mem_sequencer

Owns the absorption-matrix dual-port memory and sequences its three uses: zero-fill sweep, photon-calculator read-modify-write traffic, and host readout as 32-bit halves. Sits between the top-level SW/HW skeleton FSM, the photon calculator's absorber port and the absorption memory instances. Replaces ad-hoc muxing with one arbitrated, state-driven owner.

## Interface
- ADDR_WIDTH, 16, absorption memory address width (depth 2^ADDR_WIDTH)
- WORD_WIDTH, 64, absorption memory word width (must be 64)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_clear  in  1  pulse: begin zero-fill sweep
- calc_done  in  1  calculator finished all photons
- calc_rdaddress  in  ADDR_WIDTH  calculator read address
- calc_wraddress  in  ADDR_WIDTH  calculator write address
- calc_data  in  WORD_WIDTH  calculator write data
- calc_wren  in  1  calculator write enable
- calc_q  out  WORD_WIDTH  read data to calculator (mem_q passthrough)
- calc_reset  out  1  hold calculator in reset
- host_inc  in  1  advance readout by one 32-bit half
- host_result  out  32  current readout half-word
- host_valid  out  1  host_result valid
- readout_done  out  1  all words read out
- busy  out  1  high in CLEAR, CALC, READ_WAIT, READOUT
- mem_rdaddress  out  ADDR_WIDTH  memory read address
- mem_wraddress  out  ADDR_WIDTH  memory write address
- mem_data  out  WORD_WIDTH  memory write data
- mem_wren  out  1  memory write enable
- mem_q  in  WORD_WIDTH  memory read data, registered, 1-cycle latency from mem_rdaddress

## Operation
- States: IDLE, CLEAR, CALC, READ_WAIT, READOUT, FINISHED. Registers: state, wr_cnt, rd_cnt (ADDR_WIDTH), toggle.
- IDLE: mem_wren=0; start_clear=1 -> CLEAR, wr_cnt<=0.
- CLEAR: mem_wraddress=wr_cnt, mem_data=0, mem_wren=1; wr_cnt+1 per cycle; at wr_cnt=all-ones -> CALC (wr_cnt wraps to 0). calc_* inputs ignored.
- CALC: mem_rdaddress/wraddress/data/wren = calc_* unmodified; calc_done=1 -> READ_WAIT, rd_cnt<=0, toggle<=0. mem_wren forced 0 in the cycle calc_done is seen.
- READ_WAIT: mem_rdaddress=rd_cnt, mem_wren=0; one cycle -> READOUT.
- READOUT: mem_rdaddress=rd_cnt; host_result = toggle ? mem_q[31:0] : mem_q[63:32]; host_valid=1. host_inc with toggle=0 -> toggle<=1. host_inc with toggle=1 -> toggle<=0; if rd_cnt=all-ones -> FINISHED, else rd_cnt+1 and -> READ_WAIT.
- FINISHED: readout_done=1; start_clear=1 -> CLEAR (new run).
- calc_reset=1 in IDLE, CLEAR, FINISHED; 0 in CALC, READ_WAIT, READOUT.
- start_clear ignored outside IDLE/FINISHED; calc_done ignored outside CALC; host_inc ignored outside READOUT.
- calc_q = mem_q in all states.

## Timing
- All state/counters registered; mem_* outputs, calc_reset, busy, host_* , readout_done decoded combinationally from registered state/counters.
- Reset values (cycle after reset sampled high): state IDLE, wr_cnt=rd_cnt=0, toggle=0, mem_wren=0, mem_*address=0, mem_data=0, calc_reset=1, busy=0, host_valid=0, host_result=0, readout_done=0.
- host_result=0 whenever host_valid=0.
- Clear sweep: exactly 2^ADDR_WIDTH cycles with mem_wren=1; CALC entered the following cycle.
- Readout: each word costs 1 READ_WAIT cycle + 2 host_inc cycles; host_valid drops for the READ_WAIT cycle between words.
- Reset mid-operation: any state -> IDLE next cycle; partial clear/readout abandoned, no further writes.

## Test plan
- Reset: assert reset 2 cycles -> mem_wren=0, calc_reset=1, busy=0, host_valid=0, readout_done=0, host_result=0.
- Clear (ADDR_WIDTH=4): pulse start_clear -> 16 consecutive cycles mem_wren=1, mem_data=0, mem_wraddress 0..15; next cycle busy=1, calc_reset=0 (CALC).
- Passthrough: in CALC drive calc_wren=1, calc_wraddress=5, calc_data=64'h1122334455667788 -> same values on mem_* that cycle; calc_q tracks mem_q.
- Readout: word 0 = 64'hAABBCCDD00112233; assert calc_done -> 1 READ_WAIT cycle, then host_valid=1, host_result=32'hAABBCCDD; host_inc -> 32'h00112233; host_inc -> host_valid=0 one cycle, mem_rdaddress=1.
- End/restart (ADDR_WIDTH=4): 32 host_inc pulses -> readout_done=1, host_valid=0, calc_reset=1; start_clear restarts sweep at address 0; host_inc in FINISHED has no effect.
- Reset mid-clear at wr_cnt=7 -> next cycle mem_wren=0, IDLE; calc_done and host_inc pulses ignored; subsequent start_clear sweeps from 0.
